// File: rtl/truth_table_sequencer_if.sv
// Host/FUT-side bundle for truth_table_sequencer; the slave modport belongs to the sequencer.
// Optional TRUTH_TABLE_CHECK_EN adds the expected/mismatch/fail_idx signals.
interface truth_table_sequencer_if #(
  parameter int N_IN = 4
);
  logic                   start;
  logic                   abort;
  logic [N_IN-1:0]        fut_in;
  logic                   fut_out;
  logic                   busy;
  logic                   done;
  logic [(1<<N_IN)-1:0]   truth;
`ifdef TRUTH_TABLE_CHECK_EN
  logic [(1<<N_IN)-1:0]   expected;
  logic                   mismatch;
  logic [N_IN-1:0]        fail_idx;

  modport slave (
    input  start, abort, fut_out, expected,
    output fut_in, busy, done, truth, mismatch, fail_idx
  );
  modport master (
    output start, abort, fut_out, expected,
    input  fut_in, busy, done, truth, mismatch, fail_idx
  );
`else
  modport slave (
    input  start, abort, fut_out,
    output fut_in, busy, done, truth
  );
  modport master (
    output start, abort, fut_out,
    input  fut_in, busy, done, truth
  );
`endif
endinterface

// File: rtl/truth_table_sequencer.sv
// Sweeps an N_IN-input function through all input codes and packs its sampled output into truth.
// Optional TRUTH_TABLE_CHECK_EN compares the sweep against a latched expected table.
module truth_table_sequencer #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  truth_table_sequencer_if.slave bus
);

  localparam int              NV       = 1 << N_IN;
  localparam logic [N_IN:0]   LAST_IDX = (N_IN+1)'(NV - 1);
  localparam logic [3:0]      SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            r_state;
  logic [N_IN:0]     r_idx;
  logic [3:0]        r_cnt;
  logic [N_IN-1:0]   r_fut_in;
  logic              r_busy;
  logic              r_done;
  logic [NV-1:0]     r_truth;

  state_t            w_vec_state;
  logic [N_IN:0]     w_idx_nxt;

  // A zero settle time skips WAIT entirely and samples on the next edge.
  assign w_vec_state = (SETTLE > 0) ? S_WAIT : S_SAMPLE;
  assign w_idx_nxt   = r_idx + (N_IN+1)'(1);

`ifdef TRUTH_TABLE_CHECK_EN
  logic [NV-1:0]     r_exp;
  logic              r_mismatch;
  logic [N_IN-1:0]   r_fail_idx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_fut_in   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_truth    <= '0;
`ifdef TRUTH_TABLE_CHECK_EN
      r_exp      <= '0;
      r_mismatch <= 1'b0;
      r_fail_idx <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_truth  <= '0;
            r_idx    <= '0;
            r_fut_in <= '0;
            r_cnt    <= SETTLE_C;
            r_busy   <= 1'b1;
            r_state  <= w_vec_state;
`ifdef TRUTH_TABLE_CHECK_EN
            r_exp      <= bus.expected;
            r_mismatch <= 1'b0;
            r_fail_idx <= '0;
`endif
          end
        end

        S_WAIT: begin
          if (bus.abort) begin
            r_fut_in <= '0;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state <= S_SAMPLE;
            end
          end
        end

        S_SAMPLE: begin
          // The capture happens even when this cycle is aborted.
          r_truth[r_idx[N_IN-1:0]] <= bus.fut_out;
`ifdef TRUTH_TABLE_CHECK_EN
          if ((bus.fut_out != r_exp[r_idx[N_IN-1:0]]) && !r_mismatch) begin
            r_mismatch <= 1'b1;
            r_fail_idx <= r_idx[N_IN-1:0];
          end
`endif
          if (bus.abort) begin
            r_fut_in <= '0;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else if (r_idx == LAST_IDX) begin
            r_fut_in <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_idx    <= w_idx_nxt;
            r_fut_in <= w_idx_nxt[N_IN-1:0];
            r_cnt    <= SETTLE_C;
            r_state  <= w_vec_state;
          end
        end

        S_DONE: begin
          r_fut_in <= '0;
          r_state  <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.fut_in = r_fut_in;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.truth  = r_truth;
`ifdef TRUTH_TABLE_CHECK_EN
  assign bus.mismatch = r_mismatch;
  assign bus.fail_idx = r_fail_idx;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: a 4-input AND-OR FUT (SETTLE=1) and a 3-input LUT FUT (SETTLE=0).
module tb_truth_table_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  logic fault = 1'b0;
  logic [7:0] lut3 = 8'hAD;

  truth_table_sequencer_if #(.N_IN(4)) bus4 ();
  truth_table_sequencer_if #(.N_IN(3)) bus3 ();

  truth_table_sequencer #(.N_IN(4), .SETTLE(1)) u_seq4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  truth_table_sequencer #(.N_IN(3), .SETTLE(0)) u_seq3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3.slave)
  );

  // FUT models: (a&c)|(b&d) with optional stuck-at-0 on code 10, and an 8'hAD lookup
  assign bus4.fut_out = ((bus4.fut_in[3] & bus4.fut_in[1]) | (bus4.fut_in[2] & bus4.fut_in[0]))
                        & ~(fault && (bus4.fut_in == 4'hA));
  assign bus3.fut_out = lut3[bus3.fut_in];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a 4-input sweep and returns the number of edges from start to done.
  task automatic run4(output int cyc, input bit poke_start, input bit chk_vec);
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    cyc = 0;
    while (cyc < 100) begin
      tick();
      cyc++;
      if (bus4.done) break;
      if (chk_vec) check($sformatf("fut_in_k%0d", cyc), 32'(bus4.fut_in), 32'(cyc / 2));
      bus4.start = poke_start && (cyc == 10);
    end
    bus4.start = 1'b0;
  endtask

  initial begin
    int cyc;
    int bcnt;
    int dcnt;
    bus4.start = 1'b0;
    bus4.abort = 1'b0;
    bus3.start = 1'b0;
    bus3.abort = 1'b0;
`ifdef TRUTH_TABLE_CHECK_EN
    bus4.expected = 16'hECA0;
    bus3.expected = 8'hAD;
`endif

    #12;
    check("rst_truth4",  32'(bus4.truth),  32'h0);
    check("rst_fut_in4", 32'(bus4.fut_in), 32'h0);
    check("rst_busy4",   32'(bus4.busy),   32'h0);
    check("rst_done4",   32'(bus4.done),   32'h0);
    check("rst_truth3",  32'(bus3.truth),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Full 4-input sweep with a stray start pulse in the middle
    run4(cyc, 1'b1, 1'b1);
    check("sweep4_len",     32'(cyc),          32'd32);
    check("sweep4_truth",   32'(bus4.truth),   32'hECA0);
    check("sweep4_fut_dn",  32'(bus4.fut_in),  32'h0);
    check("sweep4_busy_dn", 32'(bus4.busy),    32'h0);
    tick();
    check("sweep4_done_1c", 32'(bus4.done),    32'h0);
    check("sweep4_fut_aft", 32'(bus4.fut_in),  32'h0);
    check("sweep4_hold",    32'(bus4.truth),   32'hECA0);

    // 3-input sweep with zero settle time
    bus3.start = 1'b1;
    tick();
    bus3.start = 1'b0;
    cyc  = 0;
    bcnt = int'(bus3.busy);
    while (cyc < 50) begin
      tick();
      cyc++;
      if (bus3.done) break;
      bcnt += int'(bus3.busy);
    end
    check("sweep3_len",   32'(cyc),        32'd8);
    check("sweep3_busy",  32'(bcnt),       32'd8);
    check("sweep3_truth", 32'(bus3.truth), 32'hAD);

    // Abort while waiting on vector 5
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    repeat (10) tick();
    check("abort5_vec", 32'(bus4.fut_in), 32'h5);
    bus4.abort = 1'b1;
    tick();
    bus4.abort = 1'b0;
    check("abort5_busy",  32'(bus4.busy),   32'h0);
    check("abort5_fut",   32'(bus4.fut_in), 32'h0);
    check("abort5_truth", 32'(bus4.truth),  32'h0000);
    dcnt = 0;
    repeat (40) begin
      tick();
      dcnt += int'(bus4.done);
    end
    check("abort5_nodone", 32'(dcnt), 32'd0);

    // Abort in the SAMPLE cycle of vector 7: that sample still lands
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    repeat (15) tick();
    bus4.abort = 1'b1;
    tick();
    bus4.abort = 1'b0;
    check("abort7_truth", 32'(bus4.truth), 32'h00A0);
    check("abort7_busy",  32'(bus4.busy),  32'h0);
    check("abort7_done",  32'(bus4.done),  32'h0);

    // Asynchronous reset mid-sweep
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    repeat (20) tick();
    check("mid_busy", 32'(bus4.busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_truth", 32'(bus4.truth),  32'h0);
    check("arst_fut",   32'(bus4.fut_in), 32'h0);
    check("arst_busy",  32'(bus4.busy),   32'h0);
    check("arst_done",  32'(bus4.done),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    check("arst_idle", 32'(bus4.busy), 32'h0);

`ifdef TRUTH_TABLE_CHECK_EN
    fault = 1'b1;
    bus4.expected = 16'hECA0;
    run4(cyc, 1'b0, 1'b0);
    check("chk_len",      32'(cyc),           32'd32);
    check("chk_truth",    32'(bus4.truth),    32'hE8A0);
    check("chk_mismatch", 32'(bus4.mismatch), 32'h1);
    check("chk_fail_idx", 32'(bus4.fail_idx), 32'hA);
    tick();
    fault = 1'b0;
    run4(cyc, 1'b0, 1'b0);
    check("chk2_mismatch", 32'(bus4.mismatch), 32'h0);
    check("chk2_truth",    32'(bus4.truth),    32'hECA0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
